// File: rtl/mul_arbiter.sv
// Round-robin arbiter that shares one multi-cycle multiplier between N requesters.
// Grants one requester at a time, latches its operands and returns the product with a done pulse.
module mul_arbiter #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   a_in,
    input  logic [N*W-1:0]   b_in,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     done,
    output logic [2*W-1:0]   result,
    output logic             busy,
    output logic             mul_start,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic             mul_rdy,
    input  logic [2*W-1:0]   mul_p
);

    localparam int SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state;
    logic [SW-1:0] ptr;
    logic [SW-1:0] sel;
    logic [SW-1:0] pick;
    logic          pick_vld;

    function automatic logic [N-1:0] onehot(input logic [SW-1:0] i);
        return N'(1) << i;
    endfunction

    function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] i);
        if (int'(i) == N - 1)
            return '0;
        return SW'(int'(i) + 1);
    endfunction

    // Walk downward from ptr+N-1 to ptr so the last hit is the first set bit at or above ptr.
    always_comb begin
        int idx;
        idx      = 0;
        pick     = ptr;
        pick_vld = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N)
                idx = idx - N;
            if (req[SW'(idx)]) begin
                pick     = SW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            sel    <= '0;
            gnt    <= '0;
            done   <= '0;
            result <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        sel   <= pick;
                        mul_a <= a_in[int'(pick)*W +: W];
                        mul_b <= b_in[int'(pick)*W +: W];
                        gnt   <= onehot(pick);
                        state <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                // mul_rdy only matters here; strobes in any other state are ignored.
                WAIT: begin
                    if (mul_rdy) begin
                        result <= mul_p;
                        done   <= onehot(sel);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= '0;
                    gnt   <= '0;
                    ptr   <= wrap_inc(sel);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign mul_start = (state == ISSUE);

endmodule
